// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART packet deframer.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LEN     = 2'd1,
        PAYLOAD = 2'd2,
        CSUM    = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         LEN_W             = 8;
    localparam int         CSUM_W            = 8;

endpackage

// File: rtl/uart_frame_rx.sv
// UART packet deframer: SYNC, LEN, LEN payload bytes, XOR checksum.
// Payload goes out as an AXI-stream packet with tlast on the final beat
// and tuser flagging a bad frame on that beat.
// Optional macro UART_FRAME_TIMEOUT_EN adds an inter-byte timeout that
// flushes the held byte as a bad last beat and returns to IDLE.
//
// state   | meaning
// IDLE    | hunting for SYNC, other bytes dropped
// LEN     | next byte is the payload length
// PAYLOAD | receiving payload, one byte held back as pending
// CSUM    | next byte is the checksum; pending byte goes out with tlast
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = 255,
    parameter int         TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       m_axis_tuser,
    output logic       busy,
    output logic       frame_error,
    output logic       len_error,
    output logic       timeout_error
);

    localparam logic [8:0] MAX_LEN_W = 9'(MAX_LEN);

    state_t              r_state, w_state_nxt;
    logic [LEN_W-1:0]    r_count, w_count_nxt;
    logic [CSUM_W-1:0]   r_csum, w_csum_nxt;
    logic                r_pend_valid, w_pend_valid_nxt;
    logic [7:0]          r_pend_data, w_pend_data_nxt;
    logic                r_out_valid;
    logic [7:0]          r_out_data;
    logic                r_out_last, r_out_user;
    logic                r_frame_err, r_len_err, r_to_err;
    logic                w_frame_err_nxt, w_len_err_nxt, w_to_err_nxt;
    logic                w_tready, w_accept, w_out_free, w_expired;
    logic                w_load, w_load_last, w_load_user;

    assign w_out_free = !r_out_valid || m_axis_tready;
    assign w_accept   = s_axis_tvalid && w_tready;

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_timer;

    // Inter-byte timer: restarts on each accepted byte, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (r_state == IDLE || w_accept) begin
            r_timer <= '0;
        end else if (r_timer != TMR_W'(TIMEOUT_CYCLES)) begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    assign w_expired = (r_state != IDLE) && (r_timer == TMR_W'(TIMEOUT_CYCLES));
`else
    assign w_expired = 1'b0;
`endif

    // Next-state, input handshake and output-register load decisions.
    always_comb begin
        w_state_nxt      = r_state;
        w_tready         = 1'b0;
        w_count_nxt      = r_count;
        w_csum_nxt       = r_csum;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_data_nxt  = r_pend_data;
        w_load           = 1'b0;
        w_load_last      = 1'b0;
        w_load_user      = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_len_err_nxt    = 1'b0;
        w_to_err_nxt     = 1'b0;
        if (w_expired) begin
            // Input stays blocked until the held byte can be flushed.
            if (!r_pend_valid || w_out_free) begin
                w_load           = r_pend_valid;
                w_load_last      = 1'b1;
                w_load_user      = 1'b1;
                w_pend_valid_nxt = 1'b0;
                w_to_err_nxt     = 1'b1;
                w_state_nxt      = IDLE;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    w_tready = 1'b1;
                    if (s_axis_tvalid && s_axis_tdata == SYNC_BYTE)
                        w_state_nxt = LEN;
                end
                LEN: begin
                    w_tready = 1'b1;
                    if (s_axis_tvalid) begin
                        if (s_axis_tdata == 8'h00 || {1'b0, s_axis_tdata} > MAX_LEN_W) begin
                            w_len_err_nxt = 1'b1;
                            w_state_nxt   = IDLE;
                        end else begin
                            w_count_nxt = s_axis_tdata;
                            w_csum_nxt  = s_axis_tdata;
                            w_state_nxt = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    w_tready = w_out_free;
                    if (s_axis_tvalid && w_tready) begin
                        w_load           = r_pend_valid;
                        w_pend_valid_nxt = 1'b1;
                        w_pend_data_nxt  = s_axis_tdata;
                        w_csum_nxt       = r_csum ^ s_axis_tdata;
                        w_count_nxt      = r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1))
                            w_state_nxt = CSUM;
                    end
                end
                CSUM: begin
                    w_tready = w_out_free;
                    if (s_axis_tvalid && w_tready) begin
                        w_load           = 1'b1;
                        w_load_last      = 1'b1;
                        w_load_user      = (s_axis_tdata != r_csum);
                        w_frame_err_nxt  = (s_axis_tdata != r_csum);
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // State, pending stage, output register and error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_csum       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_out_user   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_len_err    <= 1'b0;
            r_to_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_csum       <= w_csum_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_data  <= w_pend_data_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_len_err    <= w_len_err_nxt;
            r_to_err     <= w_to_err_nxt;
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_pend_data;
                r_out_last  <= w_load_last;
                r_out_user  <= w_load_user;
            end else if (m_axis_tready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign s_axis_tready = w_tready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tuser  = r_out_user;
    assign busy          = (r_state != IDLE);
    assign frame_error   = r_frame_err;
    assign len_error     = r_len_err;
    assign timeout_error = r_to_err;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: table of frames plus hand-written
// backpressure, mid-frame reset and (with UART_FRAME_TIMEOUT_EN) timeout.
module tb_uart_frame_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       m_axis_tlast, m_axis_tuser;
    logic       busy, frame_error, len_error, timeout_error;

    uart_frame_rx #(.TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .busy(busy), .frame_error(frame_error), .len_error(len_error), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] data; logic last; logic user; } beat_t;
    typedef struct {
        int         nb;
        logic [7:0] b [8];
        int         ne;
        logic [7:0] e [4];
        logic       user;
        int         ferr;
        int         lerr;
    } vec_t;

    beat_t      q[$];
    vec_t       vecs[5];
    int         checks = 0, failures = 0;
    int         n_ferr = 0, n_lerr = 0, n_terr = 0;
    int         stab_fail = 0;
    logic       saw_stall_block = 1'b0;
    logic       prev_stall = 1'b0;
    logic [9:0] prev_out = '0;
    logic       bp_en = 1'b0;
    int         bp_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream backpressure: ready toggles every 3 cycles when enabled.
    always @(negedge clk) begin
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt % 3 == 0) m_axis_tready = ~m_axis_tready;
        end
    end

    // Output monitor: records beats, counts pulses, checks stall stability.
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser});
            if (frame_error) n_ferr++;
            if (len_error) n_lerr++;
            if (timeout_error) n_terr++;
            if (prev_stall && (!m_axis_tvalid || prev_out != {m_axis_tdata, m_axis_tlast, m_axis_tuser}))
                stab_fail++;
            if (m_axis_tvalid && !m_axis_tready && busy && !s_axis_tready)
                saw_stall_block = 1'b1;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        #1;
        while (!s_axis_tready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 32'(n), 32'd0);
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        q.delete();
        n_ferr = 0;
        n_lerr = 0;
        n_terr = 0;
    endtask

    initial begin
        vecs[0] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03, 8'h00, 8'h00},
                    3, '{8'h11, 8'h22, 8'h33, 8'h00}, 1'b0, 0, 0};
        vecs[1] = '{6, '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04, 8'h00, 8'h00},
                    3, '{8'h11, 8'h22, 8'h33, 8'h00}, 1'b1, 1, 0};
        vecs[2] = '{6, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00},
                    1, '{8'h7E, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 0};
        vecs[3] = '{6, '{8'hA5, 8'h00, 8'hA5, 8'h01, 8'h7E, 8'h7F, 8'h00, 8'h00},
                    1, '{8'h7E, 8'h00, 8'h00, 8'h00}, 1'b0, 0, 1};
        // SYNC inside the payload is plain data: csum = 02^A5^5A = FD
        vecs[4] = '{5, '{8'hA5, 8'h02, 8'hA5, 8'h5A, 8'hFD, 8'h00, 8'h00, 8'h00},
                    2, '{8'hA5, 8'h5A, 8'h00, 8'h00}, 1'b0, 0, 0};

        repeat (3) @(negedge clk);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("reset_out", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 32'd0);
        chk("reset_pulses", {frame_error, len_error, timeout_error, busy}, 32'd0);
        chk("reset_tready", 32'(s_axis_tready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            clear_obs();
            for (int k = 0; k < vecs[i].nb; k++) send(vecs[i].b[k]);
            idle_cycles(6);
            chk($sformatf("v%0d_beats", i), 32'(q.size()), 32'(vecs[i].ne));
            for (int j = 0; j < vecs[i].ne && j < q.size(); j++) begin
                chk($sformatf("v%0d_data%0d", i, j), 32'(q[j].data), 32'(vecs[i].e[j]));
                chk($sformatf("v%0d_last%0d", i, j), 32'(q[j].last), 32'(j == vecs[i].ne - 1));
                chk($sformatf("v%0d_user%0d", i, j), 32'(q[j].user),
                    (j == vecs[i].ne - 1) ? 32'(vecs[i].user) : 32'd0);
            end
            chk($sformatf("v%0d_frame_err", i), 32'(n_ferr), 32'(vecs[i].ferr));
            chk($sformatf("v%0d_len_err", i), 32'(n_lerr), 32'(vecs[i].lerr));
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
        end

        // Backpressure: csum = 04^01^02^03^04 = 00
        clear_obs();
        stab_fail = 0;
        @(negedge clk);
        m_axis_tready = 1'b0;
        bp_cnt = 0;
        bp_en = 1'b1;
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        send(8'h03); send(8'h04); send(8'h00);
        idle_cycles(12);
        bp_en = 1'b0;
        m_axis_tready = 1'b1;
        idle_cycles(4);
        chk("bp_beats", 32'(q.size()), 32'd4);
        for (int j = 0; j < 4 && j < q.size(); j++) begin
            chk($sformatf("bp_data%0d", j), 32'(q[j].data), 32'(j + 1));
            chk($sformatf("bp_last%0d", j), 32'(q[j].last), 32'(j == 3));
            chk($sformatf("bp_user%0d", j), 32'(q[j].user), 32'd0);
        end
        chk("bp_stable", 32'(stab_fail), 32'd0);
        chk("bp_tready_blocked", 32'(saw_stall_block), 32'd1);
        chk("bp_frame_err", 32'(n_ferr), 32'd0);

        // Reset mid-payload with 11 stalled on the output and 22 pending
        clear_obs();
        @(negedge clk);
        m_axis_tready = 1'b0;
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        chk("mid_tvalid_before", 32'(m_axis_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_out", {m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser}, 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_axis_tready = 1'b1;
        idle_cycles(8);
        chk("mid_rst_no_beats", 32'(q.size()), 32'd0);

`ifdef UART_FRAME_TIMEOUT_EN
        clear_obs();
        send(8'hA5); send(8'h02); send(8'h10);
        s_axis_tvalid = 1'b0;
        begin
            int n;
            n = 0;
            while (q.size() == 0 && n < 80) begin
                @(negedge clk);
                n++;
            end
            chk("to_waited", 32'(n < 80), 32'd1);
        end
        idle_cycles(2);
        chk("to_beats", 32'(q.size()), 32'd1);
        if (q.size() > 0) begin
            chk("to_data", 32'(q[0].data), 32'h10);
            chk("to_last", 32'(q[0].last), 32'd1);
            chk("to_user", 32'(q[0].user), 32'd1);
        end
        chk("to_pulse", 32'(n_terr), 32'd1);
        chk("to_busy", 32'(busy), 32'd0);
`else
        clear_obs();
        send(8'hA5); send(8'h02); send(8'h10);
        idle_cycles(80);
        chk("nto_busy", 32'(busy), 32'd1);
        chk("nto_pulse", 32'(n_terr), 32'd0);
        chk("nto_beats", 32'(q.size()), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
